// File: rtl/osc_link_scheduler_if.sv
// osc_link_scheduler_if
// Host link bundle between the scheduler (master) and the host (slave).
//   clk_out  : link strobe, toggles once per byte presented (master -> slave)
//   data_out : link byte, 00h whenever link_oe is low       (master -> slave)
//   link_oe  : high while data_out is driven onto the bus   (master -> slave)
//   ack      : toggle acknowledge, asynchronous to clk      (slave -> master)
interface osc_link_scheduler_if;
    logic       clk_out;
    logic [7:0] data_out;
    logic       link_oe;
    logic       ack;

    modport master (output clk_out, output data_out, output link_oe, input ack);
    modport slave  (input clk_out, input data_out, input link_oe, output ack);
endinterface

// File: rtl/osc_link_scheduler.sv
// osc_link_scheduler
// Two-channel round-robin frame scheduler onto a toggle-handshaked byte link.
// Frame: header {6'b101010, ch}, length byte, len payload bytes, and with
// LINK_CSUM_EN defined a trailing XOR checksum byte. Each byte is set up on
// data_out one cycle before clk_out toggles, then the host toggles ack.
// Parameters:
//   ACK_TIMEOUT : max clk cycles waiting for one ack toggle before abort
//   GAP_CYC     : idle cycles after every frame
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_i[1:0]             : per-channel frame request (level)
//   len0_i, len1_i         : payload byte counts, sampled at grant
//   rd_en_o[1:0]           : one-cycle pull strobe to the granted source
//   rd_data0_i, rd_data1_i : source bytes, valid the cycle after rd_en_o
//   gnt_o[1:0]             : one-hot grant held for the whole frame
//   done_o / err_o         : one-cycle normal-end / timeout-abort pulses
//   link                   : host link bundle (master modport)
// Build option: LINK_CSUM_EN adds the checksum byte and its state.
module osc_link_scheduler #(
    parameter int ACK_TIMEOUT = 1023,
    parameter int GAP_CYC     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  req_i,
    input  logic [7:0]                  len0_i,
    input  logic [7:0]                  len1_i,
    output logic [1:0]                  rd_en_o,
    input  logic [7:0]                  rd_data0_i,
    input  logic [7:0]                  rd_data1_i,
    output logic [1:0]                  gnt_o,
    output logic                        done_o,
    output logic                        err_o,
    osc_link_scheduler_if.master        link
);

    localparam int TW    = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_N = (GAP_CYC < 1) ? 1 : GAP_CYC;
    localparam int GW    = $clog2(GAP_N + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_HDR, S_LEN, S_FETCH, S_LOAD, S_STROBE, S_WAIT_ACK,
`ifdef LINK_CSUM_EN
        S_CSUM,
`endif
        S_GAP
    } state_t;

    // Which byte of the frame is currently on the link.
    typedef enum logic [1:0] {
        PH_HDR, PH_LEN, PH_PAY
`ifdef LINK_CSUM_EN
        , PH_CSUM
`endif
    } phase_t;

    state_t          state_q;
    phase_t          phase_q;
    logic            sel_q;
    logic            last_q;
    logic [7:0]      cnt_q;
    logic [TW-1:0]   tmo_q;
    logic [GW-1:0]   gap_q;
    logic            abort_q;
    logic [1:0]      gnt_q;
    logic [1:0]      rd_en_q;
    logic            done_q;
    logic            err_q;
    logic            clk_out_q;
    logic [7:0]      data_q;
    logic            oe_q;
    logic            ack_s1_q;
    logic            ack_s2_q;
    logic            ack_ref_q;
`ifdef LINK_CSUM_EN
    logic [7:0]      csum_q;
`endif

    logic            sel_d;
    logic [7:0]      len_d;
    logic [7:0]      rd_byte;
    logic            ack_evt;
    logic            pay_done;

    // Tie goes to the channel not granted last; a lone requester always wins.
    assign sel_d    = (req_i == 2'b11) ? ~last_q : req_i[1];
    assign len_d    = sel_d ? len1_i : len0_i;
    assign rd_byte  = sel_q ? rd_data1_i : rd_data0_i;
    assign ack_evt  = (ack_s2_q != ack_ref_q);
    // The ack just seen closes the payload: either len was 0 (length byte
    // acked) or the last payload byte was acked.
    assign pay_done = ((phase_q == PH_LEN) && (cnt_q == 8'd0)) ||
                      ((phase_q == PH_PAY) && (cnt_q == 8'd1));

    assign gnt_o         = gnt_q;
    assign rd_en_o       = rd_en_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign link.clk_out  = clk_out_q;
    assign link.data_out = data_q;
    assign link.link_oe  = oe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_HDR;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= 8'd0;
            tmo_q     <= '0;
            gap_q     <= '0;
            abort_q   <= 1'b0;
            gnt_q     <= 2'b00;
            rd_en_q   <= 2'b00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            clk_out_q <= 1'b0;
            data_q    <= 8'h00;
            oe_q      <= 1'b0;
            ack_s1_q  <= 1'b0;
            ack_s2_q  <= 1'b0;
            ack_ref_q <= 1'b0;
`ifdef LINK_CSUM_EN
            csum_q    <= 8'h00;
`endif
        end else begin
            // Every event is consumed in the cycle it is seen; only WAIT_ACK
            // acts on it, so stray toggles elsewhere are simply dropped.
            ack_s1_q  <= link.ack;
            ack_s2_q  <= ack_s1_q;
            ack_ref_q <= ack_s2_q;
            rd_en_q   <= 2'b00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (req_i != 2'b00) state_q <= S_ARB;
                end
                S_ARB: begin
                    if (req_i == 2'b00) begin
                        state_q <= S_IDLE;
                    end else begin
                        sel_q   <= sel_d;
                        last_q  <= sel_d;
                        gnt_q   <= sel_d ? 2'b10 : 2'b01;
                        cnt_q   <= len_d;
                        abort_q <= 1'b0;
                        state_q <= S_HDR;
                    end
                end
                S_HDR: begin
                    data_q  <= {6'b101010, 1'b0, sel_q};
                    oe_q    <= 1'b1;
                    phase_q <= PH_HDR;
`ifdef LINK_CSUM_EN
                    csum_q  <= {6'b101010, 1'b0, sel_q};
`endif
                    state_q <= S_STROBE;
                end
                S_LEN: begin
                    data_q  <= cnt_q;
                    phase_q <= PH_LEN;
`ifdef LINK_CSUM_EN
                    csum_q  <= csum_q ^ cnt_q;
`endif
                    state_q <= S_STROBE;
                end
                S_FETCH: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    data_q  <= rd_byte;
                    phase_q <= PH_PAY;
`ifdef LINK_CSUM_EN
                    csum_q  <= csum_q ^ rd_byte;
`endif
                    state_q <= S_STROBE;
                end
`ifdef LINK_CSUM_EN
                S_CSUM: begin
                    data_q  <= csum_q;
                    phase_q <= PH_CSUM;
                    state_q <= S_STROBE;
                end
`endif
                S_STROBE: begin
                    clk_out_q <= ~clk_out_q;
                    tmo_q     <= '0;
                    state_q   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (ack_evt) begin
                        if (phase_q == PH_PAY) cnt_q <= cnt_q - 8'd1;
                        if (phase_q == PH_HDR) begin
                            state_q <= S_LEN;
`ifdef LINK_CSUM_EN
                        end else if (phase_q == PH_CSUM) begin
                            oe_q    <= 1'b0;
                            data_q  <= 8'h00;
                            gap_q   <= '0;
                            state_q <= S_GAP;
`endif
                        end else if (pay_done) begin
`ifdef LINK_CSUM_EN
                            state_q <= S_CSUM;
`else
                            oe_q    <= 1'b0;
                            data_q  <= 8'h00;
                            gap_q   <= '0;
                            state_q <= S_GAP;
`endif
                        end else begin
                            rd_en_q <= gnt_q;
                            state_q <= S_FETCH;
                        end
                    end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        abort_q <= 1'b1;
                        oe_q    <= 1'b0;
                        data_q  <= 8'h00;
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_q == GW'(GAP_N - 1)) begin
                        done_q  <= ~abort_q;
                        gnt_q   <= 2'b00;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osc_link_scheduler.sv
module tb_osc_link_scheduler;

    localparam int TMO = 40;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] len0, len1;
    logic [1:0] rd_en;
    logic [7:0] rd_data0, rd_data1;
    logic [1:0] gnt;
    logic       done, err;

    osc_link_scheduler_if lnk ();

    osc_link_scheduler #(.ACK_TIMEOUT(TMO), .GAP_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .len0_i     (len0),
        .len1_i     (len1),
        .rd_en_o    (rd_en),
        .rd_data0_i (rd_data0),
        .rd_data1_i (rd_data1),
        .gnt_o      (gnt),
        .done_o     (done),
        .err_o      (err),
        .link       (lnk.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Host / source / monitor model, all on the falling edge.
    logic [7:0] src0 [8];
    logic [7:0] src1 [8];
    logic [2:0] ptr0, ptr1;
    logic       pend0, pend1;
    logic       prev_co;
    logic [1:0] prev_gnt;
    logic       ack_en;
    int         ack_cd;
    int         cyc, ncap, done_cnt, err_cnt, rd_cnt;
    int         bad_gnt, bad_rd, bad_oe, bad_dz;
    int         err_cyc;
    logic       err_oe;
    logic [7:0] err_dat;
    logic [7:0] capb [512];
    logic [1:0] capg [512];
    int         capc [512];

    initial begin
        src0 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        src1 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            lnk.ack  = 1'b0;
            ack_cd   = 0;
            prev_co  = lnk.clk_out;
            prev_gnt = gnt;
            pend0    = 1'b0;
            pend1    = 1'b0;
            rd_data0 = 8'h00;
            rd_data1 = 8'h00;
        end else begin
            if (ack_cd > 0) begin
                ack_cd--;
                if (ack_cd == 0) lnk.ack = ~lnk.ack;
            end
            if (gnt == 2'b11) bad_gnt++;
            if (rd_en == 2'b11) bad_rd++;
            if (!lnk.link_oe && lnk.data_out != 8'h00) bad_dz++;
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                ptr0 = 3'd0;
                ptr1 = 3'd0;
            end
            if (pend0) begin rd_data0 = src0[ptr0]; ptr0++; pend0 = 1'b0; end
            if (pend1) begin rd_data1 = src1[ptr1]; ptr1++; pend1 = 1'b0; end
            // Garbage during the rd_en cycle; the real byte arrives one cycle later.
            if (rd_en[0]) begin pend0 = 1'b1; rd_data0 = 8'hEE; end
            if (rd_en[1]) begin pend1 = 1'b1; rd_data1 = 8'hEE; end
            rd_cnt = rd_cnt + int'(rd_en[0]) + int'(rd_en[1]);
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
                err_oe  = lnk.link_oe;
                err_dat = lnk.data_out;
            end
            if (lnk.clk_out != prev_co) begin
                if (ncap < 511) begin
                    capb[ncap] = lnk.data_out;
                    capg[ncap] = gnt;
                    capc[ncap] = cyc;
                    ncap++;
                end
                if (!lnk.link_oe) bad_oe++;
                if (ack_en) ack_cd = 4;
            end
            prev_co  = lnk.clk_out;
            prev_gnt = gnt;
        end
    end

    typedef struct {
        logic [1:0]      req;
        logic [7:0]      l0;
        logic [7:0]      l1;
        logic [1:0]      g;
        int              rd;
        int              n;
        logic [0:9][7:0] b;
    } vec_t;

    vec_t tbl [7];

    task automatic wait_gnt();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (gnt != 2'b00) return;
        end
        chk("gnt_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic wait_end(input int d0, input int e0);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (done_cnt != d0 || err_cnt != e0) return;
        end
        chk("frame_end_expired", 32'd0, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_gnt"},   32'(gnt), 32'd0);
        chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_err"},   32'(err), 32'd0);
        chk({tag, "_clk_out"}, 32'(lnk.clk_out), 32'd0);
        chk({tag, "_data"},  32'(lnk.data_out), 32'd0);
        chk({tag, "_oe"},    32'(lnk.link_oe), 32'd0);
    endtask

    task automatic run_vec(input int idx);
        vec_t       v;
        int         base, d0, e0, r0, nexp;
        logic [7:0] cs;
        v    = tbl[idx];
        base = ncap; d0 = done_cnt; e0 = err_cnt; r0 = rd_cnt;
        len0 = v.l0; len1 = v.l1; req = v.req;
        wait_gnt();
        req = 2'b00;                 // dropping req mid-frame must not shorten it
        wait_end(d0, e0);
        nexp = v.n;
        cs   = 8'h00;
        for (int k = 0; k < v.n; k++) cs = cs ^ v.b[k];
`ifdef LINK_CSUM_EN
        nexp = v.n + 1;
`endif
        chk($sformatf("v%0d_nbytes", idx), 32'(ncap - base), 32'(nexp));
        for (int k = 0; k < v.n; k++)
            chk($sformatf("v%0d_byte%0d", idx, k), 32'(capb[base + k]), 32'(v.b[k]));
`ifdef LINK_CSUM_EN
        chk($sformatf("v%0d_csum", idx), 32'(capb[base + v.n]), 32'(cs));
`endif
        chk($sformatf("v%0d_gnt", idx), 32'(capg[base]), 32'(v.g));
        chk($sformatf("v%0d_rd_en_cnt", idx), 32'(rd_cnt - r0), 32'(v.rd));
        chk($sformatf("v%0d_done", idx), 32'(done_cnt - d0), 32'd1);
        chk($sformatf("v%0d_err", idx), 32'(err_cnt - e0), 32'd0);
    endtask

    initial begin
        int base, d0, e0, r0;
        cyc = 0; ncap = 0; done_cnt = 0; err_cnt = 0; rd_cnt = 0;
        bad_gnt = 0; bad_rd = 0; bad_oe = 0; bad_dz = 0; ack_cd = 0;
        ptr0 = 3'd0; ptr1 = 3'd0; pend0 = 1'b0; pend1 = 1'b0;
        prev_co = 1'b0; prev_gnt = 2'b00; err_cyc = 0; err_oe = 1'b0; err_dat = 8'h00;
        ack_en = 1'b1;
        rst_n = 1'b0; req = 2'b00; len0 = 8'd0; len1 = 8'd0;

        //           req    l0     l1     gnt    rd n   bytes
        tbl[0] = '{2'b01, 8'd3, 8'd0, 2'b01, 3, 5,  80'hA8_03_11_22_33_00_00_00_00_00};
        tbl[1] = '{2'b10, 8'd0, 8'd0, 2'b10, 0, 2,  80'hA9_00_00_00_00_00_00_00_00_00};
        tbl[2] = '{2'b11, 8'd1, 8'd2, 2'b01, 1, 3,  80'hA8_01_11_00_00_00_00_00_00_00};
        tbl[3] = '{2'b11, 8'd1, 8'd2, 2'b10, 2, 4,  80'hA9_02_C1_C2_00_00_00_00_00_00};
        tbl[4] = '{2'b10, 8'd5, 8'd1, 2'b10, 1, 3,  80'hA9_01_C1_00_00_00_00_00_00_00};
        tbl[5] = '{2'b01, 8'd8, 8'd0, 2'b01, 8, 10, 80'hA8_08_11_22_33_44_55_66_77_88};
        tbl[6] = '{2'b01, 8'd0, 8'd9, 2'b01, 0, 2,  80'hA8_00_00_00_00_00_00_00_00_00};

        repeat (3) @(negedge clk);
        #1 chk_reset("por");
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Host never acks the header: abort after TMO cycles, then recover.
        ack_en = 1'b0;
        base = ncap; d0 = done_cnt; e0 = err_cnt; r0 = rd_cnt;
        len0 = 8'd2; req = 2'b01;
        wait_gnt();
        req = 2'b00;
        wait_end(d0, e0);
        chk("tmo_err", 32'(err_cnt - e0), 32'd1);
        chk("tmo_nbytes", 32'(ncap - base), 32'd1);
        chk("tmo_hdr", 32'(capb[base]), 32'hA8);
        chk("tmo_latency", 32'(err_cyc - capc[base]), 32'(TMO));
        chk("tmo_oe", 32'(err_oe), 32'd0);
        chk("tmo_data", 32'(err_dat), 32'd0);
        repeat (6) @(negedge clk);
        #1;
        chk("tmo_no_done", 32'(done_cnt - d0), 32'd0);
        chk("tmo_no_rd_en", 32'(rd_cnt - r0), 32'd0);
        chk("tmo_gnt_clear", 32'(gnt), 32'd0);
        ack_en = 1'b1;
        run_vec(0);

        // Reset while waiting for the length-byte ack.
        base = ncap;
        len0 = 8'd3; req = 2'b01;
        wait_gnt();
        for (int i = 0; i < 200 && (ncap - base) < 2; i++) begin
            @(negedge clk); #1;
        end
        chk("rst_reached_len", 32'(ncap - base), 32'd2);
        @(negedge clk);
        d0 = done_cnt; e0 = err_cnt;
        rst_n = 1'b0; req = 2'b00;
        #1 chk_reset("mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mid_no_err", 32'(err_cnt - e0), 32'd0);

        // Both channels held: ch0 first after reset, then alternate.
        base = ncap; d0 = done_cnt;
        len0 = 8'd1; len1 = 8'd1; req = 2'b11;
        for (int i = 0; i < 3000 && (done_cnt - d0) < 3; i++) begin
            @(negedge clk); #1;
        end
        req = 2'b00;
        chk("held_frames", 32'(done_cnt - d0), 32'd3);
`ifdef LINK_CSUM_EN
        chk("held_g0", 32'(capg[base]), 32'd1);
        chk("held_g1", 32'(capg[base + 4]), 32'd2);
        chk("held_g2", 32'(capg[base + 8]), 32'd1);
`else
        chk("held_g0", 32'(capg[base]), 32'd1);
        chk("held_g1", 32'(capg[base + 3]), 32'd2);
        chk("held_g2", 32'(capg[base + 6]), 32'd1);
`endif
        repeat (5) @(negedge clk);

        chk("gnt_onehot", 32'(bad_gnt), 32'd0);
        chk("rd_en_onehot", 32'(bad_rd), 32'd0);
        chk("oe_at_strobe", 32'(bad_oe), 32'd0);
        chk("data_zero_when_off", 32'(bad_dz), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
